// File: rtl/fmul_rr_sched.sv
// Round-robin front end that shares one pipelined fmul between NREQ requesters.
// Grants one operand pair per cycle, carries the owner ID alongside the fmul and strobes the product back.
module fmul_rr_sched #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  input  logic [N-1:0]      mul_out,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_data,
  output logic              busy
);
  // Handshake: requester i transfers on a rising edge where req_valid[i] & req_ready[i];
  // it holds valid and operands until then. Responses have no backpressure.
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(LAT + 4);
  // Stage 0 rides with mul_a/mul_b; the remaining LAT+1 stages follow the fmul.
  localparam int TD = LAT + 2;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;
  logic          issue;
  logic [TD-1:0] tv;
  logic [PW-1:0] tid [TD];
  logic [CW-1:0] inflight;
  logic [NREQ-1:0] rsp_hot;

  always_comb begin
    int j;
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = PW'(j);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign issue = found & ~hold & ~rst;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (issue && (win == PW'(i))) req_ready[i] = 1'b1;
    end
  end

  assign rsp_hot = {{(NREQ-1){1'b0}}, 1'b1} << tid[TD-1];
  assign busy    = (inflight != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      tv        <= '0;
      for (int k = 0; k < TD; k++) tid[k] <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      inflight  <= '0;
    end else begin
      tv     <= {tv[TD-2:0], issue};
      tid[0] <= win;
      for (int k = 1; k < TD; k++) tid[k] <= tid[k-1];

      if (issue) begin
        mul_a <= req_a[int'(win)*N +: N];
        mul_b <= req_b[int'(win)*N +: N];
        ptr   <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
      end else begin
        mul_a <= '0;
        mul_b <= '0;
      end

      // The final tag stage lines up with mul_out for its own operand pair.
      if (tv[TD-1]) begin
        rsp_valid <= rsp_hot;
        rsp_data  <= mul_out;
      end else begin
        rsp_valid <= '0;
      end

      case ({issue, tv[TD-1]})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end
endmodule

// File: tb/tb_fmul_rr_sched.sv
// Bench for fmul_rr_sched: stand-in fmul, queue-based requesters, a reference scoreboard
// checked every negedge, and directed scenarios with literal expectations.
module tb_fmul_rr_sched;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int W    = N + 40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              hold = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*N-1:0] req_a = '0;
  logic [NREQ*N-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [N-1:0]      mul_a, mul_b, mul_out, rsp_data;
  logic              busy;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;
  op_t pend[$];

  logic [W-1:0]  exp_q[$];
  logic [NREQ-1:0] hs_vec = '0;
  int last_srv = NREQ - 1;
  int grant_log[$];
  int hs_cyc_log[$];
  int rsp_log[$];
  int rsp_cyc_log[$];
  logic [31:0] rsp_data_log[$];
  logic [N-1:0] fp_pipe [0:LAT];

  fmul_rr_sched #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .hold(hold), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out(mul_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) return {s, e[7:0] + 8'd1, p[46:24]};
    return {s, e[7:0], p[45:23]};
  endfunction

  // Stand-in fmul: samples a/b one edge after they are registered, product out LAT edges later.
  always @(posedge clk) begin
    fp_pipe[0] <= fpmul(mul_a, mul_b);
    for (int k = 1; k <= LAT; k++) fp_pipe[k] <= fp_pipe[k-1];
  end
  assign mul_out = fp_pipe[LAT];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs_vec[i]) begin
          for (int k = 0; k < pend.size(); k++) begin
            if (pend[k].id == i) begin
              pend.delete(k);
              break;
            end
          end
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = 1'b0;
        for (int k = 0; k < pend.size(); k++) begin
          if (pend[k].id == i) begin
            req_valid[i]     = 1'b1;
            req_a[i*N +: N]  = pend[k].a;
            req_b[i*N +: N]  = pend[k].b;
            break;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int id, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    o.id = id;
    o.a  = a;
    o.b  = b;
    pend.push_back(o);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    hs_cyc_log.delete();
    rsp_log.delete();
    rsp_cyc_log.delete();
    rsp_data_log.delete();
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((pend.size() != 0 || exp_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, 64'(n >= budget), 64'd0);
  endtask

  task automatic pulse_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard / compare ----------------
  initial begin
    int w;
    int j;
    int nbusy;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_rv;
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_rsp_data", rsp_data, 0);
        exp_q.delete();
        last_srv = NREQ - 1;
        hs_vec   = '0;
      end else begin
        // Round-robin rule: scan starting just after the last requester served.
        w = -1;
        for (int k = 1; k <= NREQ; k++) begin
          j = (last_srv + k) % NREQ;
          if (w < 0 && req_valid[j]) w = j;
        end
        exp_ready = (!hold && w >= 0) ? NREQ'(1 << w) : '0;
        check("req_ready", req_ready, exp_ready);
        hs_vec = req_valid & req_ready;

        nbusy = 0;
        foreach (exp_q[k]) begin
          if (int'(exp_q[k][N+39:N+8]) > cyc && int'(exp_q[k][N+39:N+8]) - (LAT + 2) <= cyc)
            nbusy++;
        end
        check("busy", busy, 64'(nbusy != 0));

        exp_rv = '0;
        if (exp_q.size() != 0 && int'(exp_q[0][N+39:N+8]) == cyc) begin
          e = exp_q.pop_front();
          exp_rv = NREQ'(1 << int'(e[N+7:N]));
          check("rsp_data", rsp_data, e[N-1:0]);
          rsp_log.push_back(int'(e[N+7:N]));
          rsp_cyc_log.push_back(cyc);
          rsp_data_log.push_back(e[N-1:0]);
        end
        check("rsp_valid", rsp_valid, exp_rv);

        if (exp_ready != '0) begin
          exp_q.push_back({32'(cyc + LAT + 3), 8'(w), fpmul(req_a[w*N +: N], req_b[w*N +: N])});
          last_srv = w;
          grant_log.push_back(w);
          hs_cyc_log.push_back(cyc + 1);
        end
      end
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] f_tab [0:7];
    logic [31:0] p_tab [0:7];
    f_tab = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    p_tab = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
              32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // single op, 2.0 * 3.0
    clear_logs();
    push(0, 32'h40000000, 32'h40400000);
    wait_idle("t1", 40);
    check("t1_grants", grant_log.size(), 1);
    check("t1_latency", rsp_cyc_log[0] - hs_cyc_log[0], 5);
    check("t1_rsp_id", rsp_log[0], 0);
    check("t1_data", rsp_data_log[0], 32'h40C00000);
    check("t1_busy_idle", busy, 0);

    // all four from reset
    pulse_reset();
    clear_logs();
    for (int i = 0; i < NREQ; i++) push(i, f_tab[i], f_tab[i+4]);
    wait_idle("t2", 60);
    for (int i = 0; i < NREQ; i++) begin
      check("t2_grant_order", grant_log[i], i);
      check("t2_rsp_order", rsp_log[i], i);
    end
    check("t2_grant_span", hs_cyc_log[3] - hs_cyc_log[0], 3);
    check("t2_rsp_span", rsp_cyc_log[3] - rsp_cyc_log[0], 3);

    // fairness and wrap after serving req2
    clear_logs();
    push(2, f_tab[1], f_tab[2]);
    wait_idle("t3a", 40);
    clear_logs();
    push(0, f_tab[2], f_tab[3]);
    push(3, f_tab[4], f_tab[5]);
    wait_idle("t3b", 40);
    check("t3_first", grant_log[0], 3);
    check("t3_second", grant_log[1], 0);
    check("t3_rsp_first", rsp_log[0], 3);

    // hold blocks grants while an op drains
    clear_logs();
    push(0, f_tab[6], f_tab[1]);
    tick();
    tick();
    hold = 1'b1;
    push(1, f_tab[3], f_tab[3]);
    repeat (8) tick();
    check("t4_no_grant_hold", grant_log.size(), 1);
    check("t4_drain_count", rsp_log.size(), 1);
    check("t4_drain_data", rsp_data_log[0], 32'h41600000);
    hold = 1'b0;
    tick();
    check("t4_resume_count", grant_log.size(), 2);
    check("t4_resume_id", grant_log[1], 1);
    wait_idle("t4", 40);

    // reset with three ops in flight
    pulse_reset();
    clear_logs();
    push(0, f_tab[1], f_tab[1]);
    push(1, f_tab[2], f_tab[2]);
    push(2, f_tab[3], f_tab[3]);
    for (int n = 0; n < 20 && grant_log.size() < 3; n++) tick();
    check("t5_issued", grant_log.size(), 3);
    pulse_reset();
    clear_logs();
    repeat (10) tick();
    check("t5_no_rsp", rsp_log.size(), 0);
    check("t5_busy", busy, 0);
    push(1, f_tab[1], f_tab[4]);
    push(3, f_tab[2], f_tab[4]);
    wait_idle("t5", 40);
    check("t5_first_after_rst", grant_log[0], 1);
    check("t5_second_after_rst", grant_log[1], 3);

    // req3 streams eight ops back to back
    clear_logs();
    for (int k = 0; k < 8; k++) push(3, f_tab[k], 32'h40000000);
    wait_idle("t6", 80);
    check("t6_grants", grant_log.size(), 8);
    check("t6_grant_span", hs_cyc_log[7] - hs_cyc_log[0], 7);
    check("t6_rsp_span", rsp_cyc_log[7] - rsp_cyc_log[0], 7);
    for (int k = 0; k < 8; k++) begin
      check("t6_id", rsp_log[k], 3);
      check("t6_product", rsp_data_log[k], p_tab[k]);
    end
    check("t6_busy_after", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
